arm_pipelined_mem_arbiter: RTL

Sequencer for one single-ported unified instruction/data memory, shared between the Fetch stage (instruction reads) and the Memory stage (loads/stores) of the ARM pipelined processor. The block arbitrates with data-priority plus an anti-starvation counter, issues one access at a time, and waits a fixed memory latency. It returns registered read data with a one-cycle Ready pulse, and drives the StallF/StallM requests consumed by the hazard unit.

---
 rtl/arm_pipelined_mem_pkg.sv | 16 +
 rtl/arm_pipelined_mem_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/arm_pipelined_mem_pkg.sv
// Shared types for the unified instruction/data memory sequencer.
// The FSM state and the owner of the access currently in flight.
package arm_pipelined_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/arm_pipelined_mem_arbiter.sv
// Single-ported memory sequencer shared by Fetch and Memory stages.
// Data-priority arbitration with an anti-starvation counter for fetches.
module arm_pipelined_mem_arbiter
    import arm_pipelined_mem_pkg::*;
#(
    parameter int BusWidth    = 32,
    parameter int MemLatency  = 2,
    parameter int StarveLimit = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                IReq,
    input  logic [BusWidth-1:0] IAddr,
    output logic [BusWidth-1:0] IRData,
    output logic                IReady,
    input  logic                DReq,
    input  logic                DWrite,
    input  logic [BusWidth-1:0] DAddr,
    input  logic [BusWidth-1:0] DWData,
    output logic [BusWidth-1:0] DRData,
    output logic                DReady,
    output logic                MemEn,
    output logic                MemWE,
    output logic [BusWidth-1:0] MemAddr,
    output logic [BusWidth-1:0] MemWData,
    input  logic [BusWidth-1:0] MemRData,
    output logic                StallF,
    output logic                StallM
);

    localparam int LW = (MemLatency > 1) ? $clog2(MemLatency) : 1;
    localparam int SW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
    localparam logic [LW-1:0] LAT_INIT   = LW'(MemLatency - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(StarveLimit);

    state_t        state, state_nxt;
    owner_t        owner;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          issue;
    logic          grant_i;
    logic          grant_d;
    logic          capture;

    // Issue is suppressed while reset is held so the memory never sees a
    // strobe from a request that is still pending at reset time.
    always_comb begin
        grant_i = IReq & (~DReq | (starve_cnt == STARVE_MAX));
        grant_d = DReq & ~grant_i;
        issue   = (state == IDLE) & (IReq | DReq) & ~reset;
        capture = (state == WAIT) & (lat_cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = (grant_d & DWrite) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        MemEn    = issue;
        MemWE    = issue & grant_d & DWrite;
        MemAddr  = '0;
        MemWData = '0;
        if (issue) begin
            MemAddr  = grant_d ? DAddr : IAddr;
            MemWData = grant_d ? DWData : '0;
        end
        IReady = (state == DONE) & (owner == OWN_I);
        DReady = (state == DONE) & (owner == OWN_D);
        StallF = IReq & ~IReady & ~reset;
        StallM = DReq & ~DReady & ~reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_I;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if (issue) begin
                owner   <= grant_d ? OWN_D : OWN_I;
                lat_cnt <= LAT_INIT;
                if (grant_i) begin
                    starve_cnt <= '0;
                end else if (IReq && (starve_cnt != STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
        end
    end

    // Read data holds until the next capture for the same port; stores
    // never pass through WAIT, so they cannot disturb DRData.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IRData <= '0;
            DRData <= '0;
        end else if (capture) begin
            if (owner == OWN_I) begin
                IRData <= MemRData;
            end else begin
                DRData <= MemRData;
            end
        end
    end

endmodule
